// File: rtl/brick_game_ctrl.sv
// Brick-breaker game sequencer: tick generation, per-tick brick collision scan,
// and brick/score/lives/status bookkeeping. Optional `PAUSE_EN adds a pause input.
module brick_game_ctrl #(
    parameter int NUM_BRICKS = 12,
    parameter int TICK_DIV   = 4999999,
    parameter int BRICK_SIZE = 40,
    parameter int BALL_SIZE  = 10,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            ball_x,
    input  logic [9:0]            ball_y,
    input  logic                  ball_lost,
`ifdef PAUSE_EN
    input  logic                  pause,
`endif
    output logic [3:0]            brk_idx,
    input  logic [9:0]            brk_x,
    input  logic [9:0]            brk_y,
    output logic                  move_en,
    output logic                  serve,
    output logic                  bounce_x,
    output logic                  bounce_y,
    output logic [NUM_BRICKS-1:0] brick_alive,
    output logic [SCORE_W-1:0]    score,
    output logic [2:0]            lives,
    output logic                  finish,
    output logic                  win
);

    localparam int TW = (TICK_DIV < 1) ? 1 : $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_MOVE,
        S_SCAN,
        S_CHECK,
        S_OVER,
        S_WIN
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [3:0]            idx_q, idx_d;
    logic                  move_q, move_d;
    logic                  serve_q, serve_d;
    logic                  bx_q, bx_d;
    logic                  by_q, by_d;
    logic                  finish_q, finish_d;
    logic                  win_q, win_d;
    logic [NUM_BRICKS-1:0] alive_q, alive_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [2:0]            lives_q, lives_d;
    logic                  lost_q, lost_d;
    logic                  start_q;

    logic                  start_rise;
    logic                  paused;
    logic                  alive_sel;
    logic                  hit;
    logic                  last_idx;
    logic                  lost_now;
    logic [10:0]           ball_l, ball_r, ball_t, ball_b;
    logic [10:0]           brk_l, brk_r, brk_t, brk_b;

    assign start_rise = start & ~start_q;

`ifdef PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // 11-bit edges so ball/brick right and bottom edges never wrap
    assign ball_l = 11'(ball_x);
    assign ball_r = 11'(ball_x) + 11'(BALL_SIZE);
    assign ball_t = 11'(ball_y);
    assign ball_b = 11'(ball_y) + 11'(BALL_SIZE);
    assign brk_l  = 11'(brk_x);
    assign brk_r  = 11'(brk_x) + 11'(BRICK_SIZE);
    assign brk_t  = 11'(brk_y);
    assign brk_b  = 11'(brk_y) + 11'(BRICK_SIZE);

    always_comb begin
        alive_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
            if (4'(i) == idx_q) alive_sel = alive_q[i];
        end
    end

    assign hit = alive_sel && (ball_r > brk_l) && (ball_l < brk_r)
                           && (ball_b > brk_t) && (ball_t < brk_b);
    assign last_idx = (idx_q == 4'(NUM_BRICKS - 1));
    assign lost_now = lost_q | ball_lost;

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        idx_d    = '0;
        move_d   = 1'b0;
        serve_d  = 1'b0;
        bx_d     = 1'b0;
        by_d     = 1'b0;
        alive_d  = alive_q;
        score_d  = score_q;
        lives_d  = lives_q;
        lost_d   = lost_q;

        case (state_q)
            S_IDLE: begin
                alive_d = '1;
                score_d = '0;
                lives_d = 3'(LIVES);
                lost_d  = 1'b0;
                tick_d  = '0;
                if (start_rise) begin
                    serve_d = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                lost_d = lost_now;
                if (!paused) begin
                    if (tick_q == TW'(TICK_DIV)) begin
                        tick_d  = '0;
                        move_d  = 1'b1;
                        state_d = S_MOVE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            S_MOVE: begin
                lost_d  = lost_now;
                state_d = S_SCAN;
            end

            S_SCAN: begin
                lost_d = lost_now;
                if (hit) begin
                    for (int unsigned i = 0; i < NUM_BRICKS; i++) begin
                        if (4'(i) == idx_q) alive_d[i] = 1'b0;
                    end
                    if (score_q != '1) score_d = score_q + 1'b1;
                    if ((ball_l < brk_l) || (ball_r > brk_r)) bx_d = 1'b1;
                    else                                       by_d = 1'b1;
                    state_d = S_CHECK;
                end else if (last_idx) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            S_CHECK: begin
                lost_d = 1'b0;
                if (alive_q == '0) begin
                    state_d = S_WIN;
                end else if (lost_now && lives_q == 3'd1) begin
                    lives_d = '0;
                    state_d = S_OVER;
                end else if (lost_now) begin
                    lives_d = lives_q - 1'b1;
                    serve_d = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_OVER, S_WIN: begin
                lost_d = 1'b0;
                // Reinitialise on the way into IDLE so the renderer sees fresh values at once
                if (start_rise) begin
                    alive_d = '1;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                    tick_d  = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        finish_d = (state_d == S_OVER);
        win_d    = (state_d == S_WIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            idx_q    <= '0;
            move_q   <= 1'b0;
            serve_q  <= 1'b0;
            bx_q     <= 1'b0;
            by_q     <= 1'b0;
            finish_q <= 1'b0;
            win_q    <= 1'b0;
            alive_q  <= '1;
            score_q  <= '0;
            lives_q  <= 3'(LIVES);
            lost_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            move_q   <= move_d;
            serve_q  <= serve_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            finish_q <= finish_d;
            win_q    <= win_d;
            alive_q  <= alive_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            lost_q   <= lost_d;
            start_q  <= start;
        end
    end

    assign brk_idx     = idx_q;
    assign move_en     = move_q;
    assign serve       = serve_q;
    assign bounce_x    = bx_q;
    assign bounce_y    = by_q;
    assign brick_alive = alive_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign finish      = finish_q;
    assign win         = win_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Directed bench for brick_game_ctrl: a 12-brick instance for timing, hits and
// lives, and a 2-brick instance for the win path.
module tb_brick_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start_a, lost_a;
    logic [9:0]  ballx_a, bally_a, brkx_a, brky_a;
    logic [3:0]  idx_a;
    logic        move_a, serve_a, bx_a, by_a, fin_a, win_a;
    logic [11:0] alive_a;
    logic [7:0]  score_a;
    logic [2:0]  lives_a;
`ifdef PAUSE_EN
    logic        pause_a;
`endif

    logic        start_b, lost_b;
    logic [9:0]  ballx_b, bally_b, brkx_b, brky_b;
    logic [3:0]  idx_b;
    logic        move_b, serve_b, bx_b, by_b, fin_b, win_b;
    logic [1:0]  alive_b;
    logic [7:0]  score_b;
    logic [2:0]  lives_b;
`ifdef PAUSE_EN
    logic        pause_b;
    assign pause_b = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    int mv;

    // Brick ROM A: brick 5 at (60,40), others in a row at y=300, x=50*i
    assign brkx_a = (idx_a == 4'd5) ? 10'd60 : 10'(32'(idx_a) * 50);
    assign brky_a = (idx_a == 4'd5) ? 10'd40 : 10'd300;
    // Brick ROM B: (100,100) and (200,100)
    assign brkx_b = (idx_b == 4'd0) ? 10'd100 : 10'd200;
    assign brky_b = 10'd100;

    brick_game_ctrl #(.NUM_BRICKS(12), .TICK_DIV(9), .BRICK_SIZE(40),
                      .BALL_SIZE(10), .LIVES(3), .SCORE_W(8)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .ball_x(ballx_a), .ball_y(bally_a), .ball_lost(lost_a),
`ifdef PAUSE_EN
        .pause(pause_a),
`endif
        .brk_idx(idx_a), .brk_x(brkx_a), .brk_y(brky_a),
        .move_en(move_a), .serve(serve_a), .bounce_x(bx_a), .bounce_y(by_a),
        .brick_alive(alive_a), .score(score_a), .lives(lives_a),
        .finish(fin_a), .win(win_a)
    );

    brick_game_ctrl #(.NUM_BRICKS(2), .TICK_DIV(3), .BRICK_SIZE(40),
                      .BALL_SIZE(10), .LIVES(3), .SCORE_W(8)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .ball_x(ballx_b), .ball_y(bally_b), .ball_lost(lost_b),
`ifdef PAUSE_EN
        .pause(pause_b),
`endif
        .brk_idx(idx_b), .brk_x(brkx_b), .brk_y(brky_b),
        .move_en(move_b), .serve(serve_b), .bounce_x(bx_b), .bounce_y(by_b),
        .brick_alive(alive_b), .score(score_b), .lives(lives_b),
        .finish(fin_b), .win(win_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Negedges until the selected pulse is seen; -1 on timeout
    task automatic wait_for(input int sel, output int cnt);
        logic seen;
        cnt = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = move_a;
                1:       seen = serve_a;
                2:       seen = bx_a | by_a;
                3:       seen = move_b;
                default: seen = bx_b | by_b;
            endcase
            if (seen) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0; lost_a = 1'b0; ballx_a = 10'd0; bally_a = 10'd0;
        start_b = 1'b0; lost_b = 1'b0; ballx_b = 10'd100; bally_b = 10'd100;
`ifdef PAUSE_EN
        pause_a = 1'b0;
`endif
        step(3);
        check("rst_pulses", {26'd0, move_a, serve_a, bx_a, by_a, fin_a, win_a}, 32'd0);
        check("rst_idx",    idx_a, 0);
        check("rst_alive",  alive_a, 32'hFFF);
        check("rst_score",  score_a, 0);
        check("rst_lives",  lives_a, 3);
        reset = 1'b1;
        step(2);

        // Start edge: serve for one cycle, then tick every 24 clocks
        start_a = 1'b1;
        step(1);
        check("serve_hi", serve_a, 1);
        step(1);
        check("serve_lo", serve_a, 0);
        start_a = 1'b0;
        wait_for(0, n);
        check("first_move", n, 9);
        wait_for(0, n);
        check("tick_period", n, 24);

        // Top-face hit on brick 5
        ballx_a = 10'd65; bally_a = 10'd40;
        wait_for(2, n);
        check("hit5_latency", n, 7);
        check("hit5_by", by_a, 1);
        check("hit5_bx", bx_a, 0);
        check("hit5_alive", alive_a, 32'hFDF);
        check("hit5_score", score_a, 1);
        step(1);
        check("hit5_by_pulse", by_a, 0);
        wait_for(0, n);
        check("post_hit_move", n, 10);
        wait_for(0, n);
        check("dead_brick_period", n, 24);
        check("dead_brick_score", score_a, 1);

        // Side hit on brick 7
        ballx_a = 10'd345; bally_a = 10'd300;
        wait_for(2, n);
        check("hit7_latency", n, 9);
        check("hit7_bx", bx_a, 1);
        check("hit7_by", by_a, 0);
        check("hit7_alive", alive_a, 32'hF5F);
        check("hit7_score", score_a, 2);
        ballx_a = 10'd0; bally_a = 10'd0;

        // Two lost balls in WAIT, each served again
        step(1); lost_a = 1'b1; step(1); lost_a = 1'b0;
        wait_for(0, n);
        wait_for(1, n);
        check("lost1_serve", n, 14);
        check("lost1_lives", lives_a, 2);
        lost_a = 1'b1; step(1); lost_a = 1'b0;
        wait_for(0, n);
        wait_for(1, n);
        check("lost2_serve", n, 14);
        check("lost2_lives", lives_a, 1);

        // Third loss lands in the CHECK cycle itself
        wait_for(0, n);
        step(13);
        lost_a = 1'b1;
        step(1);
        lost_a = 1'b0;
        check("over_finish", fin_a, 1);
        check("over_lives", lives_a, 0);
        check("over_no_serve", serve_a, 0);
        step(5);
        check("over_hold", fin_a, 1);

        // Restart from OVER returns to IDLE with fresh values
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        check("restart_finish", fin_a, 0);
        check("restart_lives", lives_a, 3);
        check("restart_score", score_a, 0);
        check("restart_alive", alive_a, 32'hFFF);

        // Two-brick instance: clear both, loss in the same tick is ignored
        start_b = 1'b1;
        step(1);
        check("b_serve", serve_b, 1);
        start_b = 1'b0;
        wait_for(3, n);
        check("b_first_move", n, 4);
        wait_for(4, n);
        check("b_hit0_latency", n, 2);
        check("b_hit0_by", by_b, 1);
        check("b_hit0_alive", alive_b, 2);
        check("b_hit0_score", score_b, 1);
        ballx_b = 10'd200;
        step(1); lost_b = 1'b1; step(1); lost_b = 1'b0;
        wait_for(3, n);
        wait_for(4, n);
        check("b_hit1_latency", n, 3);
        check("b_hit1_alive", alive_b, 0);
        check("b_hit1_win_pending", win_b, 0);
        step(1);
        check("b_win", win_b, 1);
        check("b_win_lives", lives_b, 3);
        check("b_win_finish", fin_b, 0);
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        check("b_restart_win", win_b, 0);
        check("b_restart_alive", alive_b, 3);
        check("b_restart_score", score_b, 0);

        // Asynchronous reset in the middle of a scan
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        wait_for(0, n);
        check("rs_first_move", n, 10);
        step(3);
        check("rs_mid_idx", idx_a, 2);
        reset = 1'b0;
        #2;
        check("rs_idx", idx_a, 0);
        check("rs_pulses", {26'd0, move_a, serve_a, bx_a, by_a, fin_a, win_a}, 32'd0);
        check("rs_lives", lives_a, 3);
        step(1);
        reset = 1'b1;
        step(2);

`ifdef PAUSE_EN
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
        step(4);
        pause_a = 1'b1;
        mv = 0;
        repeat (50) begin
            @(negedge clk);
            mv += int'(move_a);
        end
        check("pause_hold", mv, 0);
        pause_a = 1'b0;
        wait_for(0, n);
        check("pause_resume", n, 6);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/brick_game_ctrl.md
# brick_game_ctrl

Game sequencer for the VGA brick-breaker. It generates the game tick and pulses the ball datapath to advance. Each tick it then scans the brick array one brick per clock for a collision, and it owns the brick-alive vector, score, lives and game-over/win status. The pixel renderer reads these as plain registers.

## Interface
Parameters:
- NUM_BRICKS, 12: brick count (1..16).
- TICK_DIV, 4999999: clocks per game tick, minus 1.
- BRICK_SIZE, 40: brick edge length in pixels.
- BALL_SIZE, 10: ball edge length in pixels.
- LIVES, 3: lives at serve (1..7).
- SCORE_W, 8: score width.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low.
- start, in, 1: start/restart request, level; rising edge detected internally.
- ball_x, in, 10: ball left edge, from ball datapath.
- ball_y, in, 10: ball top edge.
- ball_lost, in, 1: one-cycle pulse when the ball passes the bottom edge.
- brk_idx, out, 4: brick index to the position ROM.
- brk_x, in, 10: left edge of brick brk_idx, combinational in the same cycle.
- brk_y, in, 10: top edge of brick brk_idx, combinational in the same cycle.
- move_en, out, 1: one-cycle pulse; ball datapath advances on this edge.
- serve, out, 1: one-cycle pulse; ball datapath reloads its serve position.
- bounce_x, out, 1: one-cycle pulse requesting ball x-direction inversion.
- bounce_y, out, 1: one-cycle pulse requesting ball y-direction inversion.
- brick_alive, out, NUM_BRICKS: one bit per brick, 1 = alive.
- score, out, SCORE_W: bricks destroyed.
- lives, out, 3: remaining lives.
- finish, out, 1: game over.
- win, out, 1: all bricks cleared.

## Operation
- States: IDLE, WAIT, MOVE, SCAN, CHECK, OVER, WIN.
- IDLE:
  - Holds brick_alive all ones, score 0, lives = LIVES.
  - A start rising edge pulses serve, then goes to WAIT.
- WAIT:
  - tick_cnt counts 0..TICK_DIV.
  - At TICK_DIV, tick_cnt wraps to 0 and the state goes to MOVE.
- MOVE: move_en = 1 for exactly one cycle, then SCAN with brk_idx = 0.
- SCAN:
  - One brick per cycle, idx 0..NUM_BRICKS-1.
  - A brick is hit when it is alive and all of these hold (strict compares):
    - ball_x+BALL_SIZE > brk_x
    - ball_x < brk_x+BRICK_SIZE
    - ball_y+BALL_SIZE > brk_y
    - ball_y < brk_y+BRICK_SIZE
  - On the first hit:
    - Clear the brick's alive bit.
    - Increment score; saturate at all ones.
    - Pulse bounce_x if ball_x < brk_x or ball_x+BALL_SIZE > brk_x+BRICK_SIZE; otherwise pulse bounce_y.
    - Abort the scan and go to CHECK.
  - At most one hit per tick.
  - After the last index with no hit, go to CHECK.
- ball_lost is latched into lost_flag in any state except IDLE/OVER/WIN. lost_flag clears in CHECK.
- CHECK, in priority order:
  1. brick_alive == 0 → WIN.
  2. lost_flag with lives == 1 → lives 0, OVER.
  3. lost_flag otherwise → lives−1, serve pulse, WAIT.
  4. Otherwise → WAIT.
- OVER: finish = 1. WIN: win = 1. In both, a start rising edge goes to IDLE, which reinitialises everything.
- start edges in WAIT/MOVE/SCAN/CHECK are ignored.

## Timing
- Reset values:
  - State IDLE, tick_cnt 0, brk_idx 0.
  - move_en, serve, bounce_x, bounce_y, finish, win all 0.
  - brick_alive all ones, score 0, lives = LIVES, lost_flag 0.
- All outputs are registered.
- Start edge to serve: the start edge is sampled at edge N; serve is high during cycle N+1.
- Tick period: TICK_DIV+1 clocks in WAIT. The full loop is TICK_DIV+1 + 1 (MOVE) + scan length + 1 (CHECK) clocks.
- Scan timing:
  - First SCAN cycle is the cycle after move_en.
  - ball_x/ball_y must already reflect the move on that cycle.
  - Scan length: hit index + 1 cycles, or NUM_BRICKS with no hit.
- Bounce/score/alive updates all occur on the same edge that leaves SCAN.
- ball_lost arriving in the same cycle as CHECK is taken by that CHECK.
- Reset asserted mid-scan returns immediately to reset values; no pulse is stretched.

## Configuration
- PAUSE_EN defined:
  - Adds input port pause (1 bit, level).
  - While pause = 1 in WAIT, tick_cnt holds and no tick occurs.
  - Other states complete normally and stop in WAIT.
- PAUSE_EN undefined: no pause port; the tick free-runs.

## Test plan
- Reset, then start (TICK_DIV=9):
  - serve pulses one cycle after the edge.
  - move_en pulses every 10+1+NUM_BRICKS+1 = 24 clocks with no hit.
- Ball (0,0), brick 5 at (60,40): ball_x=65, ball_y=40 at scan:
  - Scan takes 6 cycles.
  - brick_alive[5] = 0, score 1, bounce_y pulse.
- ball_x=55 against the same brick: bounce_x pulse, not bounce_y.
- Three ball_lost pulses across ticks:
  - lives 3→2→1→0.
  - Two serve pulses, then finish=1.
  - A start edge returns to IDLE with lives 3 and score 0.
- NUM_BRICKS=2: hit both bricks in successive ticks → win=1 after the second CHECK. A ball_lost in the same tick does not change lives.
- PAUSE_EN with pause held 50 clocks in WAIT → no move_en during the hold; tick resumes with the count preserved.
